src_io_unit: RTL and testbench
==============================

Name: src_io_unit

Overview:
- Parametrised successor to the single INPORT/OUTPORT pair of the Mini SRC top level.
- Provides NUM_IN buffered input channels, each with its own FIFO, and NUM_OUT latched output channels with write strobes.
- Adds a status/error register.
- Sits between the datapath's port-access bus and external devices; the CPU addresses channels with a select code.

Parameters:
- DATA_W, 32, width of every data word.
- NUM_IN, 2, number of input channels (1..4).
- NUM_OUT, 2, number of output channels (1..4).
- IN_DEPTH, 4, entries per input FIFO; power of 2, minimum 2.
- SEL_W, 3, width of the channel select; NUM_IN+NUM_OUT must be at most 2^SEL_W - 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_IN*DATA_W  input words; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_IN  per-channel word offered.
- in_ready  out  NUM_IN  per-channel FIFO can accept; equals not-full.
- cpu_sel  in  SEL_W  channel select.
- cpu_rd  in  1  read request, one cycle.
- cpu_wr  in  1  write request, one cycle.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  registered read data.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata is valid.
- out_data  out  NUM_OUT*DATA_W  latched output words.
- out_strobe  out  NUM_OUT  one-cycle pulse when the corresponding out_data word updates.

Behaviour:
- Address map:
  - sel 0..NUM_IN-1: input channel pop.
  - sel NUM_IN..NUM_IN+NUM_OUT-1: output channel k = sel-NUM_IN.
  - sel 2^SEL_W-1: STATUS.
  - All other values are unmapped.
- Reset (asynchronous, any cycle, including mid-access):
  - All FIFOs empty; pointers and counts zero.
  - in_ready all 1; cpu_rdata 0; cpu_rvalid 0.
  - out_data all 0; out_strobe 0; sticky bits 0.
- Input FIFO per channel:
  - Push when in_valid[i] and in_ready[i].
  - in_ready[i] comes from the registered count (count != IN_DEPTH). When full, a push is refused even if a pop occurs in the same cycle.
  - Pointers wrap modulo IN_DEPTH; count width is clog2(IN_DEPTH+1).
  - Push and pop in the same cycle on a non-empty, non-full FIFO: count is unchanged and both occur.
- Read of input channel i, cpu_rd=1, cpu_wr=0:
  - Non-empty: pop the head word. Next cycle cpu_rdata = word, cpu_rvalid = 1.
  - Empty: no pop. Next cycle cpu_rdata = 0, cpu_rvalid = 1, UNDERFLOW sticky set. A push to the same channel in the same cycle is not bypassed; that word stays queued.
- Write to output channel k, cpu_wr=1, cpu_rd=0:
  - Next cycle out_data[k] = cpu_wdata and out_strobe[k] = 1 for exactly one cycle.
  - Back-to-back writes give back-to-back strobes.
- Read of an output channel: returns the current out_data[k] next cycle with cpu_rvalid = 1. No side effect.
- Read of STATUS: returns the value next cycle with cpu_rvalid = 1. Layout:
  - bits [NUM_IN-1:0]: non-empty flags.
  - bits [8+NUM_IN-1:8]: full flags.
  - bit 30: UNDERFLOW.
  - bit 31: BADACC.
  - All other bits 0.
  - The read clears bits 30 and 31 in the same edge that captures them. A sticky event in that same cycle wins: the bit stays set.
- Set BADACC and perform nothing for any of:
  - cpu_rd and cpu_wr asserted together.
  - A write to an input channel or STATUS.
  - Any access to an unmapped select.
- cpu_rvalid still pulses for a BADACC read, with rdata 0. No rvalid for writes.
- Read latency is exactly 1 cycle; a new request may be issued every cycle.

Test Plan:
1. Reset mid-burst with FIFO 0 holding 3 words → in_ready=2'b11, out_data=0, STATUS read returns 0x00000000.
2. Push 0xA1,0xA2,0xA3,0xA4 into channel 0 (IN_DEPTH=4) → in_ready[0]=0 after the 4th. A 5th push of 0xA5 with a simultaneous pop is refused. Four reads return 0xA1..0xA4 in order; STATUS then shows bit0=0.
3. Read empty channel 1 → cpu_rdata=0, rvalid=1. STATUS read returns bit30=1; a second STATUS read returns bit30=0.
4. Write 0xDEADBEEF to sel=2 then 0x12345678 to sel=3 on consecutive cycles → out_strobe pulses 01 then 10. out_data words hold those values; a read of sel=2 returns 0xDEADBEEF.
5. cpu_rd=cpu_wr=1 with sel=2, then a write to sel=0 → out_data unchanged, no strobes, STATUS bit31=1.
6. Wrap-around: 10 interleaved push/pop pairs on channel 1 with data 1..10 → reads return 1..10, count never exceeds 1, no flags set.

Source files
------------

// File: rtl/src_io_unit.sv
// src_io_unit: buffered input channels, latched output channels
// and a sticky status register on the CPU port-access bus.
module src_io_unit #(
  parameter int DATA_W   = 32,
  parameter int NUM_IN   = 2,
  parameter int NUM_OUT  = 2,
  parameter int IN_DEPTH = 4,
  parameter int SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [SEL_W-1:0]          cpu_sel,
  input  logic                      cpu_rd,
  input  logic                      cpu_wr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_rvalid,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_strobe
);

  localparam int PW = $clog2(IN_DEPTH);
  localparam int CW = $clog2(IN_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(IN_DEPTH);
  localparam logic [SEL_W-1:0] ST_SEL = '1;

  logic [DATA_W-1:0] mem [NUM_IN][IN_DEPTH];
  logic [PW-1:0]     wptr [NUM_IN];
  logic [PW-1:0]     rptr [NUM_IN];
  logic [CW-1:0]     cnt  [NUM_IN];

  logic              und_q, bad_q;
  logic              rd_only, wr_only, both;
  logic              hit_in, hit_out, hit_st;
  logic              und_ev, bad_ev, st_rd;
  logic [NUM_IN-1:0] push, pop, nempty, full;
  logic [NUM_OUT-1:0] wr_out;
  logic [DATA_W-1:0] status, rd_word;

  // Decode the CPU access, FIFO flags and next read word.
  always_comb begin
    rd_only = cpu_rd & ~cpu_wr;
    wr_only = cpu_wr & ~cpu_rd;
    both    = cpu_rd & cpu_wr;
    hit_in  = 1'b0;
    hit_out = 1'b0;
    und_ev  = 1'b0;
    push    = '0;
    pop     = '0;
    nempty  = '0;
    full    = '0;
    wr_out  = '0;
    rd_word = '0;
    status  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      nempty[i] = cnt[i] != '0;
      full[i]   = cnt[i] == FULL;
      push[i]   = in_valid[i] & ~full[i];
      if (cpu_sel == SEL_W'(i)) begin
        hit_in = 1'b1;
        if (rd_only) begin
          if (nempty[i]) begin
            pop[i]  = 1'b1;
            rd_word = mem[i][rptr[i]];
          end else begin
            und_ev = 1'b1;
          end
        end
      end
      status[i]     = nempty[i];
      status[8 + i] = full[i];
    end
    status[30] = und_q;
    status[31] = bad_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (cpu_sel == SEL_W'(NUM_IN + k)) begin
        hit_out = 1'b1;
        if (wr_only) wr_out[k] = 1'b1;
        if (rd_only) rd_word = out_data[k*DATA_W +: DATA_W];
      end
    end
    hit_st = cpu_sel == ST_SEL;
    st_rd  = rd_only & hit_st;
    if (st_rd) rd_word = status;
    bad_ev = both
           | (wr_only & (hit_in | hit_st))
           | ((cpu_rd | cpu_wr) & ~(hit_in | hit_out | hit_st));
  end

  assign in_ready = ~full;

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_IN; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PW'(1);
        if (pop[i])  rptr[i] <= rptr[i] + PW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (push[i]) mem[i][wptr[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  // Registered read port, output latches and sticky error bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      out_data   <= '0;
      out_strobe <= '0;
      und_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_rd;
      cpu_rdata  <= rd_word;
      out_strobe <= wr_out;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (wr_out[k]) out_data[k*DATA_W +: DATA_W] <= cpu_wdata;
      end
      und_q <= und_ev | (und_q & ~st_rd);
      bad_q <= bad_ev | (bad_q & ~st_rd);
    end
  end

endmodule

// File: tb/tb_src_io_unit.sv
// tb_src_io_unit: directed self-checking bench for src_io_unit.
// Inputs change 1 time unit after the rising edge; outputs sampled there.
module tb_src_io_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [1:0]  in_valid = '0;
  logic [1:0]  in_ready;
  logic [2:0]  cpu_sel = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic [63:0] out_data;
  logic [1:0]  out_strobe;

  int checks = 0;
  int errors = 0;

  src_io_unit dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cpu_sel(cpu_sel),
    .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .out_data(out_data),
    .out_strobe(out_strobe)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] s);
    cpu_sel = s;
    cpu_rd  = 1'b1;
    cpu_wr  = 1'b0;
    tick();
    cpu_rd  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] s, input logic [31:0] d);
    cpu_sel   = s;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    cpu_rd    = 1'b0;
    tick();
    cpu_wr    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;

    // 1: reset in the middle of a push burst
    in_valid = 2'b01;
    for (int n = 0; n < 3; n++) begin
      in_data[31:0] = 32'h11 + 32'(n);
      tick();
    end
    reset = 1'b1;
    #1;
    chk("rst_ready", 64'(in_ready), 64'(2'b11));
    chk("rst_out", out_data, 64'h0);
    chk("rst_rvalid", 64'(cpu_rvalid), 64'h0);
    chk("rst_strobe", 64'(out_strobe), 64'h0);
    in_valid = 2'b00;
    tick();
    reset = 1'b0;
    rd(3'd7);
    chk("rst_status", 64'(cpu_rdata), 64'h0);
    chk("rst_status_rv", 64'(cpu_rvalid), 64'h1);

    // 2: fill channel 0, refused push with a pop, drain
    in_valid = 2'b01;
    for (int n = 0; n < 4; n++) begin
      in_data[31:0] = 32'hA1 + 32'(n);
      tick();
    end
    in_valid = 2'b00;
    chk("full_ready", 64'(in_ready), 64'(2'b10));
    rd(3'd7);
    chk("full_status", 64'(cpu_rdata), 64'h101);
    in_valid = 2'b01;
    in_data[31:0] = 32'hA5;
    rd(3'd0);
    in_valid = 2'b00;
    chk("pop_a1", 64'(cpu_rdata), 64'hA1);
    chk("pop_a1_rv", 64'(cpu_rvalid), 64'h1);
    chk("after_pop_ready", 64'(in_ready), 64'(2'b11));
    rd(3'd0);
    chk("pop_a2", 64'(cpu_rdata), 64'hA2);
    rd(3'd0);
    chk("pop_a3", 64'(cpu_rdata), 64'hA3);
    rd(3'd0);
    chk("pop_a4", 64'(cpu_rdata), 64'hA4);
    rd(3'd7);
    chk("drained_status", 64'(cpu_rdata), 64'h0);

    // 3: underflow on empty channel 1
    rd(3'd1);
    chk("uf_rdata", 64'(cpu_rdata), 64'h0);
    chk("uf_rvalid", 64'(cpu_rvalid), 64'h1);
    rd(3'd7);
    chk("uf_status", 64'(cpu_rdata), 64'h4000_0000);
    rd(3'd7);
    chk("uf_cleared", 64'(cpu_rdata), 64'h0);
    tick();
    chk("idle_rvalid", 64'(cpu_rvalid), 64'h0);

    // 4: output channel writes
    wr(3'd2, 32'hDEADBEEF);
    chk("strobe0", 64'(out_strobe), 64'(2'b01));
    chk("rvalid_on_wr", 64'(cpu_rvalid), 64'h0);
    wr(3'd3, 32'h12345678);
    chk("strobe1", 64'(out_strobe), 64'(2'b10));
    chk("out_words", out_data, 64'h12345678_DEADBEEF);
    tick();
    chk("strobe_idle", 64'(out_strobe), 64'h0);
    rd(3'd2);
    chk("rd_out0", 64'(cpu_rdata), 64'hDEADBEEF);
    rd(3'd3);
    chk("rd_out1", 64'(cpu_rdata), 64'h12345678);

    // 5: bad accesses
    cpu_sel = 3'd2;
    cpu_wdata = 32'h0BAD0BAD;
    cpu_rd = 1'b1;
    cpu_wr = 1'b1;
    tick();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    chk("rdwr_strobe", 64'(out_strobe), 64'h0);
    chk("rdwr_out", out_data, 64'h12345678_DEADBEEF);
    wr(3'd0, 32'h55);
    chk("wr_in_strobe", 64'(out_strobe), 64'h0);
    chk("wr_in_out", out_data, 64'h12345678_DEADBEEF);
    rd(3'd7);
    chk("bad_status", 64'(cpu_rdata), 64'h8000_0000);
    rd(3'd5);
    chk("unmapped_rdata", 64'(cpu_rdata), 64'h0);
    chk("unmapped_rvalid", 64'(cpu_rvalid), 64'h1);
    rd(3'd7);
    chk("unmapped_status", 64'(cpu_rdata), 64'h8000_0000);
    rd(3'd7);
    chk("bad_cleared", 64'(cpu_rdata), 64'h0);

    // 6: wrap-around on channel 1
    for (int n = 1; n <= 10; n++) begin
      in_valid = 2'b10;
      in_data[63:32] = 32'(n);
      tick();
      in_valid = 2'b00;
      chk("wrap_ready", 64'(in_ready), 64'(2'b11));
      rd(3'd1);
      chk("wrap_data", 64'(cpu_rdata), 64'(n));
    end
    rd(3'd7);
    chk("wrap_status", 64'(cpu_rdata), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
